// File: rtl/led_scan_pkg.sv
// Shared types and sizing helpers for the LED matrix scanner and its blink timer.
package led_scan_pkg;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_e;

    localparam int BRIGHT_W = 4;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_matrix_scan_if.sv
// Register-side and pin-side signal bundle of the LED matrix scanner.
interface led_matrix_scan_if #(
    parameter int COLS = 4,
    parameter int ROWS = 3
);
    localparam int N     = ROWS * COLS;
    localparam int IDX_W = led_scan_pkg::cnt_width(N);

    logic                              en;
    logic [N-1:0]                      led_on;
    logic [N-1:0]                      led_blink;
    logic [led_scan_pkg::BRIGHT_W-1:0] brightness;
    logic [COLS-1:0]                   led_x;
    logic [ROWS-1:0]                   led_y;
    logic                              frame_tick;
    logic [IDX_W-1:0]                  scan_idx;

    modport master (
        output en, led_on, led_blink, brightness,
        input  led_x, led_y, frame_tick, scan_idx
    );

    modport slave (
        input  en, led_on, led_blink, brightness,
        output led_x, led_y, frame_tick, scan_idx
    );

endinterface

// File: rtl/led_blink_timer.sv
// Counts completed frames and toggles the blink phase every BLINK_FRAMES frames;
// holds its state while the scan is disabled.
module led_blink_timer
    import led_scan_pkg::*;
#(
    parameter int BLINK_FRAMES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic frame_tick,
    output logic blink_phase
);
    localparam int FC_W = cnt_width(BLINK_FRAMES);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

    logic [FC_W-1:0] frame_cnt_r;
    logic            blink_phase_r;

    // Frame counter and blink phase; phase 1 means blinking LEDs are dark.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_r   <= {FC_W{1'b0}};
            blink_phase_r <= 1'b0;
        end else if (en && frame_tick) begin
            if (frame_cnt_r == FC_LAST) begin
                frame_cnt_r   <= {FC_W{1'b0}};
                blink_phase_r <= ~blink_phase_r;
            end else begin
                frame_cnt_r   <= frame_cnt_r + FC_W'(1'b1);
            end
        end
    end

    assign blink_phase = blink_phase_r;

endmodule

// File: rtl/led_matrix_scan.sv
// Multiplexed ROWS x COLS LED matrix driver: blank gap + dwell slot per LED, with
// per-LED on/blink control. Define LED_PWM_EN to add global brightness PWM.
module led_matrix_scan
    import led_scan_pkg::*;
#(
    parameter int COLS         = 4,
    parameter int ROWS         = 3,
    parameter int DWELL        = 16384,
    parameter int BLANK_CYC    = 64,
    parameter int BLINK_FRAMES = 32
) (
    input  logic              clk,
    input  logic              rst,
    led_matrix_scan_if.slave  bus
);
    localparam int N     = ROWS * COLS;
    localparam int IDX_W = cnt_width(N);
    localparam int COL_W = cnt_width(COLS);
    localparam int ROW_W = cnt_width(ROWS);
    localparam int CYC_W = cnt_width((DWELL > BLANK_CYC) ? DWELL : BLANK_CYC);

    localparam logic [CYC_W-1:0] DWELL_LAST = CYC_W'(DWELL - 1);
    localparam logic [CYC_W-1:0] BLANK_LAST = CYC_W'(BLANK_CYC - 1);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);

    scan_state_e      state_r,   state_nxt_s;
    logic [CYC_W-1:0] cyc_r,     cyc_nxt_s;
    logic [COL_W-1:0] col_r,     col_nxt_s;
    logic [ROW_W-1:0] row_r,     row_nxt_s;
    logic [IDX_W-1:0] idx_r,     idx_nxt_s;
    logic             tick_nxt_s;

    logic [COLS-1:0]  led_x_r,   x_nxt_s;
    logic [ROWS-1:0]  led_y_r,   y_nxt_s;
    logic             frame_tick_r;
    logic [IDX_W-1:0] scan_idx_r;

    logic             blink_phase_s;
    logic             pwm_gate_s;
    logic             lit_s;

`ifdef LED_PWM_EN
    logic [BRIGHT_W-1:0] pwm_cnt_s;

    assign pwm_cnt_s  = BRIGHT_W'(cyc_r);
    assign pwm_gate_s = (pwm_cnt_s < bus.brightness);
`else
    logic unused_brightness_s;

    assign unused_brightness_s = ^bus.brightness;
    assign pwm_gate_s          = 1'b1;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_BLANK;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Cycle and slot counters; idx tracks row*COLS+col without a multiplier.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_r <= {CYC_W{1'b0}};
            col_r <= {COL_W{1'b0}};
            row_r <= {ROW_W{1'b0}};
            idx_r <= {IDX_W{1'b0}};
        end else begin
            cyc_r <= cyc_nxt_s;
            col_r <= col_nxt_s;
            row_r <= row_nxt_s;
            idx_r <= idx_nxt_s;
        end
    end

    // Next-state logic: blank gap, dwell slot, then advance column before row.
    always_comb begin
        state_nxt_s = state_r;
        cyc_nxt_s   = cyc_r;
        col_nxt_s   = col_r;
        row_nxt_s   = row_r;
        idx_nxt_s   = idx_r;
        tick_nxt_s  = 1'b0;
        if (!bus.en) begin
            state_nxt_s = ST_BLANK;
            cyc_nxt_s   = {CYC_W{1'b0}};
            col_nxt_s   = {COL_W{1'b0}};
            row_nxt_s   = {ROW_W{1'b0}};
            idx_nxt_s   = {IDX_W{1'b0}};
        end else begin
            case (state_r)
                ST_BLANK: begin
                    if (cyc_r == BLANK_LAST) begin
                        state_nxt_s = ST_DRIVE;
                        cyc_nxt_s   = {CYC_W{1'b0}};
                    end else begin
                        cyc_nxt_s   = cyc_r + CYC_W'(1'b1);
                    end
                end
                ST_DRIVE: begin
                    if (cyc_r == DWELL_LAST) begin
                        state_nxt_s = ST_BLANK;
                        cyc_nxt_s   = {CYC_W{1'b0}};
                        if (col_r == COL_LAST) begin
                            col_nxt_s = {COL_W{1'b0}};
                            if (row_r == ROW_LAST) begin
                                row_nxt_s  = {ROW_W{1'b0}};
                                idx_nxt_s  = {IDX_W{1'b0}};
                                tick_nxt_s = 1'b1;
                            end else begin
                                row_nxt_s  = row_r + ROW_W'(1'b1);
                                idx_nxt_s  = idx_r + IDX_W'(1'b1);
                            end
                        end else begin
                            col_nxt_s = col_r + COL_W'(1'b1);
                            idx_nxt_s = idx_r + IDX_W'(1'b1);
                        end
                    end else begin
                        cyc_nxt_s = cyc_r + CYC_W'(1'b1);
                    end
                end
                default: begin
                    state_nxt_s = ST_BLANK;
                    cyc_nxt_s   = {CYC_W{1'b0}};
                end
            endcase
        end
    end

    assign lit_s = bus.led_on[idx_r] & ~(bus.led_blink[idx_r] & blink_phase_s) & pwm_gate_s;

    // Line drive pattern: at most one column high and one row low.
    always_comb begin
        x_nxt_s = {COLS{1'b0}};
        y_nxt_s = {ROWS{1'b1}};
        if ((state_r == ST_DRIVE) && lit_s) begin
            x_nxt_s[col_r] = 1'b1;
            y_nxt_s[row_r] = 1'b0;
        end else begin
            x_nxt_s = {COLS{1'b0}};
            y_nxt_s = {ROWS{1'b1}};
        end
    end

    // Output registers, one cycle behind the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_x_r      <= {COLS{1'b0}};
            led_y_r      <= {ROWS{1'b1}};
            frame_tick_r <= 1'b0;
            scan_idx_r   <= {IDX_W{1'b0}};
        end else begin
            led_x_r      <= x_nxt_s;
            led_y_r      <= y_nxt_s;
            frame_tick_r <= tick_nxt_s;
            scan_idx_r   <= idx_r;
        end
    end

    led_blink_timer #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink (
        .clk         (clk),
        .rst         (rst),
        .en          (bus.en),
        .frame_tick  (frame_tick_r),
        .blink_phase (blink_phase_s)
    );

    assign bus.led_x      = led_x_r;
    assign bus.led_y      = led_y_r;
    assign bus.frame_tick = frame_tick_r;
    assign bus.scan_idx   = scan_idx_r;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed bench for led_matrix_scan (COLS=4, ROWS=3, DWELL=8, BLANK_CYC=2, BLINK_FRAMES=2).
module tb_led_matrix_scan;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    led_matrix_scan_if #(.COLS(4), .ROWS(3)) bus ();

    led_matrix_scan #(
        .COLS(4), .ROWS(3), .DWELL(8), .BLANK_CYC(2), .BLINK_FRAMES(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef LED_PWM_EN
    led_matrix_scan_if #(.COLS(4), .ROWS(3)) p_bus ();

    led_matrix_scan #(
        .COLS(4), .ROWS(3), .DWELL(32), .BLANK_CYC(2), .BLINK_FRAMES(2)
    ) p_dut (
        .clk (clk),
        .rst (rst),
        .bus (p_bus)
    );
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Expected {frame_tick, scan_idx, led_x, led_y} k edges after scan start:
    // 10-cycle slots (2 blank + 8 drive), outputs one cycle late, 120-cycle frames.
    function automatic logic [11:0] model(input int k, input logic [11:0] on, input logic [11:0] bl);
        int s;
        logic [3:0] x;
        logic [2:0] y;
        logic tick;
        logic ph;
        s    = (k / 10) % 12;
        x    = 4'b0000;
        y    = 3'b111;
        tick = ((k % 120) == 119);
        ph   = (((k / 120) % 4) >= 2);
        if (((k % 10) >= 2) && on[s] && !(bl[s] && ph)) begin
            x = 4'b0001 << (s % 4);
            y = ~(3'b001 << (s / 4));
        end
        return {tick, 4'(s), x, y};
    endfunction

    function automatic logic [11:0] obs_main();
        return {bus.frame_tick, bus.scan_idx, bus.led_x, bus.led_y};
    endfunction

    initial begin
        bus.en         = 1'b0;
        bus.led_on     = 12'h000;
        bus.led_blink  = 12'h000;
        bus.brightness = 4'd15;
`ifdef LED_PWM_EN
        p_bus.en         = 1'b0;
        p_bus.led_on     = 12'hFFF;
        p_bus.led_blink  = 12'h000;
        p_bus.brightness = 4'd4;
`endif
        rst = 1'b1;
        repeat (3) step();
        chk("reset", obs_main(), 12'h007);

        // All LEDs on: two full frames.
        rst        = 1'b0;
        bus.en     = 1'b1;
        bus.led_on = 12'hFFF;
        for (int k = 0; k < 240; k++) begin
            step();
            chk($sformatf("all_on k=%0d", k), obs_main(), model(k, 12'hFFF, 12'h000));
        end

        // Only row 1, col 1.
        bus.led_on = 12'h020;
        for (int k = 240; k < 360; k++) begin
            step();
            chk($sformatf("single k=%0d", k), obs_main(), model(k, 12'h020, 12'h000));
        end

        // Reset mid-slot (blink phase is 1 here; must clear).
        bus.led_on = 12'hFFF;
        for (int k = 360; k < 366; k++) begin
            step();
            chk($sformatf("pre_rst k=%0d", k), obs_main(), model(k, 12'hFFF, 12'h000));
        end
        rst = 1'b1;
        step();
        chk("rst_mid_slot", obs_main(), 12'h007);
        step();
        chk("rst_hold", obs_main(), 12'h007);

        // Blink on LED 0: lit frames 0-1, dark 2-3, lit 4-5.
        rst           = 1'b0;
        bus.led_on    = 12'h001;
        bus.led_blink = 12'h001;
        for (int k = 0; k < 720; k++) begin
            step();
            chk($sformatf("blink k=%0d", k), obs_main(), model(k, 12'h001, 12'h001));
        end

        // Drop en in the DRIVE of slot 5.
        bus.led_on    = 12'hFFF;
        bus.led_blink = 12'h000;
        for (int k = 720; k < 775; k++) begin
            step();
            chk($sformatf("pre_dis k=%0d", k), obs_main(), model(k, 12'hFFF, 12'h000));
        end
        bus.en = 1'b0;
        step();
        chk("dis_first", obs_main(), model(775, 12'hFFF, 12'h000));
        for (int i = 0; i < 19; i++) begin
            step();
            chk($sformatf("dis i=%0d", i), obs_main(), 12'h007);
        end
        bus.en = 1'b1;
        for (int k = 0; k < 120; k++) begin
            step();
            chk($sformatf("reen k=%0d", k), obs_main(), model(k, 12'hFFF, 12'h000));
        end

`ifdef LED_PWM_EN
        // DWELL=32, brightness 4: lit on drive cycles 0-3 and 16-19; then brightness 0.
        p_bus.en = 1'b1;
        for (int k = 0; k < 34; k++) begin
            step();
            chk($sformatf("pwm4 k=%0d", k), {5'b00000, p_bus.led_x, p_bus.led_y},
                ((k >= 2) && (((k - 2) % 16) < 4)) ? 12'h00E : 12'h007);
        end
        p_bus.brightness = 4'd0;
        for (int k = 34; k < 68; k++) begin
            step();
            chk($sformatf("pwm0 k=%0d", k), {5'b00000, p_bus.led_x, p_bus.led_y}, 12'h007);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
